// File: rtl/matrix_key_event.sv
// matrix_key_event: debounces a 4x4 key map and queues per-key press/release events (KEY_RELEASE_EVT_EN enables release events)
module matrix_key_event #(
    parameter int CLK_PER_MS  = 100_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_100M,
    input  logic        rst_p,
    input  logic        en,
    input  logic [15:0] key_in,
    output logic [15:0] key_state,
    output logic        evt_valid,
    output logic [4:0]  evt_data,
    input  logic        evt_ready,
    output logic        overflow
);
    localparam int TW = $clog2(CLK_PER_MS + 1);
    localparam int SW = $clog2(DEBOUNCE_MS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t         state_q, state_d;
    logic [15:0]    key_s_q, cand_q, diff_q, diff_d, key_state_q, key_state_d, new_diff;
    logic [TW-1:0]  tick_q;
    logic [SW-1:0]  stab_q;
    logic [4:0]     mem_q [FIFO_DEPTH];
    logic [4:0]     last_q, evt;
    logic [PW-1:0]  wr_q, rd_q;
    logic [PW:0]    cnt_q;
    logic [3:0]     idx;
    logic           tick, push, pop, wr, ovf_q;
    assign tick      = tick_q == TW'(CLK_PER_MS - 1);
    assign pop       = evt_valid & evt_ready;
    assign wr        = push & ((cnt_q != (PW+1)'(FIFO_DEPTH)) | pop);
    assign key_state = key_state_q;
    assign evt_valid = cnt_q != '0;
    assign evt_data  = evt_valid ? mem_q[rd_q] : last_q;
    assign overflow  = ovf_q;
`ifdef KEY_RELEASE_EVT_EN
    assign new_diff  = key_state_q ^ ~cand_q;
`else
    assign new_diff  = ~cand_q & ~key_state_q;
`endif
    // synchroniser, ms tick and stability counter; debounce freezes while en is low
    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            key_s_q <= 16'hffff;
            cand_q  <= 16'hffff;
            tick_q  <= '0;
            stab_q  <= '0;
        end else begin
            key_s_q <= key_in;
            if (en) begin
                tick_q <= tick ? '0 : tick_q + 1'b1;
                if (key_s_q != cand_q) begin
                    cand_q <= key_s_q;
                    stab_q <= '0;
                end else if (tick && stab_q != SW'(DEBOUNCE_MS)) begin
                    stab_q <= stab_q + 1'b1;
                end
            end
        end
    end
    // lowest pending changed key in the scan mask
    always_comb begin
        idx = '0;
        for (int k = 15; k >= 0; k--) if (diff_q[k]) idx = 4'(k);
    end
    // accept a stable new map, then emit one event per changed key, lowest index first
    always_comb begin
        state_d     = state_q;
        diff_d      = diff_q;
        key_state_d = key_state_q;
        push        = 1'b0;
`ifdef KEY_RELEASE_EVT_EN
        evt         = {~key_state_q[idx], idx};
`else
        evt         = {1'b0, idx};
`endif
        if (en && state_q == IDLE && stab_q == SW'(DEBOUNCE_MS) && ~cand_q != key_state_q) begin
            key_state_d = ~cand_q;
            diff_d      = new_diff;
            state_d     = |new_diff ? SCAN : IDLE;
        end else if (en && state_q == SCAN) begin
            push    = 1'b1;
            diff_d  = diff_q & ~(16'b1 << idx);
            state_d = |diff_d ? SCAN : IDLE;
        end
    end
    // FSM and debounced map registers
    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            state_q     <= IDLE;
            diff_q      <= '0;
            key_state_q <= '0;
        end else begin
            state_q     <= state_d;
            diff_q      <= diff_d;
            key_state_q <= key_state_d;
        end
    end
    // event storage; contents only matter where the occupancy count says so
    always_ff @(posedge clk_100M) begin
        if (wr) mem_q[wr_q] <= evt;
    end
    // FIFO pointers, occupancy, held output and sticky overflow
    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= mem_q[rd_q];
            end
            cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
            if (push && !wr) ovf_q <= 1'b1;
        end
    end
endmodule
